// File: rtl/piso_tx.sv
// piso_tx: valid/ready parallel-in, MSB-first serial-out transmitter with frame markers.
// Define PISO_TX_PARITY_EN to append an even-parity bit after each word.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             fin;
  logic             accept;

  assign at_last = (state == SHIFT) && (cnt == LAST);

`ifdef PISO_TX_PARITY_EN
  logic par;

  assign fin  = (state == PAR);
  assign sout = (state == SHIFT) ? sreg[WIDTH-1] :
                (state == PAR)   ? par : 1'b0;
  assign sout_valid = (state == SHIFT) || (state == PAR);
`else
  assign fin  = at_last;
  assign sout = (state == SHIFT) ? sreg[WIDTH-1] : 1'b0;
  assign sout_valid = (state == SHIFT);
`endif

  // Ready on the final frame bit lets frames run back to back.
  assign in_ready   = !reset && ((state == IDLE) || fin);
  assign accept     = in_valid && in_ready;
  assign sout_first = (state == SHIFT) && (cnt == '0);
  assign sout_last  = fin;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef PISO_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= d;
      cnt   <= '0;
`ifdef PISO_TX_PARITY_EN
      par   <= ^d;
`endif
    end else begin
      unique case (state)
        IDLE: ;
        SHIFT: begin
          if (at_last) begin
`ifdef PISO_TX_PARITY_EN
            state <= PAR;
`else
            state <= IDLE;
`endif
          end else begin
            sreg <= sreg << 1;
            cnt  <= cnt + 1'b1;
          end
        end
`ifdef PISO_TX_PARITY_EN
        PAR: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx (WIDTH=4).
// Expectations follow PISO_TX_PARITY_EN when it is defined for the build.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] d;
  logic       in_valid;
  logic       in_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_first;
  logic       sout_last;

  int checks;
  int failures;

  piso_tx #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_first (sout_first),
    .sout_last  (sout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded limit, required finish");
    $fatal(1);
  end

  // Outputs are sampled at negedge; inputs change at negedge too.
  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b1;
    d = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || sout_valid !== 1'b0 || sout !== 1'b0 ||
          sout_first !== 1'b0 || sout_last !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: rdy=%b v=%b s=%b f=%b l=%b, required all 0",
                 i, in_ready, sout_valid, sout, sout_first, sout_last);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sout_valid !== 1'b1 || sout_first !== 1'b1 || sout !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_accept: v=%b f=%b s=%b, required 1 1 1",
               sout_valid, sout_first, sout);
    end
    repeat (FL + 1) @(negedge clk);
  endtask

  // exp5 holds the expected frame bits, first bit at index 4.
  task automatic test_frame(input logic [3:0] w, input logic [4:0] exp5);
    checks++;
    if (in_ready !== 1'b1 || sout_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_idle: rdy=%b v=%b, required 1 0", in_ready, sout_valid);
    end
    d = w;
    in_valid = 1'b1;
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (sout_valid !== 1'b1 || sout !== exp5[5-i] ||
          sout_first !== (i == 1) || sout_last !== (i == FL) ||
          in_ready !== (i == FL)) begin
        failures++;
        $display("FAIL frame d=%b cyc%0d: v=%b s=%b f=%b l=%b rdy=%b, required 1 %b %b %b %b",
                 w, i, sout_valid, sout, sout_first, sout_last, in_ready,
                 exp5[5-i], (i == 1), (i == FL), (i == FL));
      end
    end
    @(negedge clk);
    checks++;
    if (sout_valid !== 1'b0 || in_ready !== 1'b1 || sout_last !== 1'b0) begin
      failures++;
      $display("FAIL frame_end d=%b: v=%b rdy=%b l=%b, required 0 1 0",
               w, sout_valid, in_ready, sout_last);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] ev;
`ifdef PISO_TX_PARITY_EN
    ev = 10'b1011101100;
`else
    ev = 10'b0010110110;
`endif
    d = 4'b1011;
    in_valid = 1'b1;
    for (int i = 1; i <= 2 * FL; i++) begin
      @(negedge clk);
      if (i == 1) d = 4'b0110;
      if (i == FL + 1) in_valid = 1'b0;
      checks++;
      if (sout_valid !== 1'b1 || sout !== ev[2*FL-i] ||
          sout_first !== (i == 1 || i == FL + 1) ||
          sout_last !== (i == FL || i == 2 * FL)) begin
        failures++;
        $display("FAIL b2b cyc%0d: v=%b s=%b f=%b l=%b, required 1 %b %b %b",
                 i, sout_valid, sout, sout_first, sout_last, ev[2*FL-i],
                 (i == 1 || i == FL + 1), (i == FL || i == 2 * FL));
      end
    end
    @(negedge clk);
    checks++;
    if (sout_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: v=%b, required 0", sout_valid);
    end
  endtask

  task automatic test_busy_ignore;
    logic [4:0] ev;
    ev = 5'b10111;
    d = 4'b1011;
    in_valid = 1'b1;
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      in_valid = (i == 2 || i == 3);
      if (i == 2) d = 4'b1111;
      checks++;
      if (sout_valid !== 1'b1 || sout !== ev[5-i] ||
          (i <= 3 && in_ready !== 1'b0)) begin
        failures++;
        $display("FAIL busy cyc%0d: v=%b s=%b rdy=%b, required 1 %b %b",
                 i, sout_valid, sout, in_ready, ev[5-i], 1'b0);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sout_valid !== 1'b0) begin
        failures++;
        $display("FAIL busy_no_second cyc%0d: v=%b, required 0", i, sout_valid);
      end
    end
  endtask

  task automatic test_reset_mid;
    d = 4'b1011;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || sout_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_cyc2: rdy=%b v=%b, required 0 1", in_ready, sout_valid);
    end
    @(negedge clk);
    checks++;
    if (sout_valid !== 1'b0 || sout !== 1'b0 || sout_first !== 1'b0 ||
        sout_last !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_cyc3: v=%b s=%b f=%b l=%b rdy=%b, required all 0",
               sout_valid, sout, sout_first, sout_last, in_ready);
    end
    reset = 1'b0;
    #1;
    test_frame(4'b0110, 5'b01100);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    d = 4'b0000;
    test_reset;
    test_frame(4'b1011, 5'b10111);
    test_frame(4'b0110, 5'b01100);
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
